ps2_rx_frame: RTL

PS/2 device-to-host frame receiver for the keyboard input path. It synchronizes and glitch-filters the raw PS2_CLK/PS2_DAT pins, deframes 11-bit frames (start, 8 data bits LSB first, odd parity, stop) and emits one-cycle byte strobes. It sits directly upstream of the scan-code consumers (last-code register, key decoder, key status register), feeding them `data_out`/`data_ready`. A watchdog recovers from truncated frames.

---
 rtl/ps2_rx_frame_if.sv | 10 +
 rtl/ps2_rx_frame.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame_if.sv
// Byte-output bundle of the PS/2 frame receiver toward the scan-code consumers.
interface ps2_rx_frame_if;
    logic [7:0] data_out;
    logic       data_ready;
    logic       frame_err;
    logic       busy;

    modport master (output data_out, output data_ready, output frame_err, output busy);
    modport slave  (input  data_out, input  data_ready, input  frame_err, input  busy);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: pin sync, clock glitch filter, 11-bit deframer, watchdog.
// Define PS2_PARITY_CHECK_EN to reject frames with bad parity or stop bit.
//
// state  | meaning
// IDLE   | waiting for a start bit (0) on a filtered falling edge
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | stop bit; completes the frame and raises data_ready or frame_err
module ps2_rx_frame #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    ps2_rx_frame_if.master bus
);

    localparam int               WD_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]       FILT_LAST = 8'(FILTER_LEN - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state, state_nxt;
    logic            clk_s1, clk_s2, dat_s1, dat_s2;
    logic            clk_filt;
    logic [7:0]      filt_cnt;
    logic            fall;
    logic            flip;
    logic [7:0]      shreg;
    logic [2:0]      bit_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic            timeout;
    logic            frame_ok;
    logic            ready_nxt, err_nxt, load_byte;
    logic [7:0]      data_out_r;
    logic            ready_r, err_r;
`ifdef PS2_PARITY_CHECK_EN
    logic            par_bit;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Flip only after FILTER_LEN consecutive disagreeing samples.
    assign flip = (clk_s2 != clk_filt) && (filt_cnt == FILT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_filt <= 1'b1;
            filt_cnt <= 8'd0;
            fall     <= 1'b0;
        end else begin
            fall <= flip && clk_filt;
            if (clk_s2 == clk_filt || flip)
                filt_cnt <= 8'd0;
            else
                filt_cnt <= filt_cnt + 8'd1;
            if (flip)
                clk_filt <= ~clk_filt;
        end
    end

    // A fall in the same cycle as the terminal count wins over the timeout.
    assign timeout = (state != IDLE) && !fall && (wd_cnt == WD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wd_cnt <= '0;
        else if (state == IDLE || fall)
            wd_cnt <= '0;
        else if (wd_cnt != WD_MAX)
            wd_cnt <= wd_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!dat_s2) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = dat_s2 && (^{shreg, par_bit});
`else
    assign frame_ok = 1'b1;
`endif

    always_comb begin
        ready_nxt = 1'b0;
        err_nxt   = 1'b0;
        load_byte = 1'b0;
        if (timeout) begin
            err_nxt = 1'b1;
        end else if (state == STOP && fall) begin
            ready_nxt = frame_ok;
            load_byte = frame_ok;
            err_nxt   = !frame_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= 8'd0;
            bit_cnt    <= 3'd0;
            data_out_r <= 8'd0;
            ready_r    <= 1'b0;
            err_r      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            if (state == IDLE && fall && !dat_s2) begin
                bit_cnt <= 3'd0;
            end else if (state == DATA && fall) begin
                shreg   <= {dat_s2, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
`ifdef PS2_PARITY_CHECK_EN
            if (state == PARITY && fall)
                par_bit <= dat_s2;
`endif
            if (load_byte)
                data_out_r <= shreg;
            ready_r <= ready_nxt;
            err_r   <= err_nxt;
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.data_ready = ready_r;
    assign bus.frame_err  = err_r;
    assign bus.busy       = (state != IDLE);

endmodule
